sample_uart_tx: RTL and testbench

//   Downstream stage of the waveform generators. Accepts one 8-bit sample per in_valid pulse,

---
 rtl/sample_uart_tx.sv | 156 +++++++++++++++
 tb/tb_sample_uart_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sample_uart_tx.sv
// Sample FIFO feeding an 8N1 UART transmitter. Bursty sample strobes are buffered and drops are flagged.
// Define SAMPLE_UART_TX_PARITY_EN to add an even-parity bit, which gives 8E1 framing.
module sample_uart_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int BCW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW           = $clog2(FIFO_DEPTH);
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]    DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;

    // ---------------- sample FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop;

    // A full FIFO still accepts a sample when the FSM frees a slot in the same cycle.
    assign push       = in_valid && ((count != DEPTH_C) || pop);
    assign fifo_full  = (count == DEPTH_C);
    assign fifo_count = count;

    // NOTE: the storage array has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // NOTE: sequential state uses non-blocking assignments, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count + (PW + 1)'(push) - (PW + 1)'(pop);
            overflow <= in_valid && !push;
        end
    end

    // ---------------- transmit FSM ----------------
    state_t         state, state_d;
    logic [BCW-1:0] baud_cnt, baud_d;
    logic [2:0]     bit_idx, bit_d;
    logic [7:0]     shift, shift_d;
    logic           tx_d, baud_done;

    assign baud_done = (baud_cnt == BAUD_LAST);

    // NOTE: every signal this block writes gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt + 1'b1;
        bit_d   = bit_idx;
        shift_d = shift;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state)
            ST_IDLE: begin
                baud_d = '0;
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shift[0];
                if (baud_done) begin
                    baud_d  = '0;
                    // Rotation leaves the byte intact after bit 7, ready for the parity bit.
                    shift_d = {shift[0], shift[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef SAMPLE_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                tx_d = ^shift;
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (count != '0) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // tx and busy are registered from the current state, so the line trails the FSM by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            shift    <= shift_d;
            tx       <= tx_d;
            busy     <= (state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_sample_uart_tx.sv
// Self-checking bench for sample_uart_tx. A timeline model predicts each frame's start edge and checks the line every cycle.
// The bit period is shortened to 17 clocks (integer divide) so that the long bursts finish quickly.
module tb_sample_uart_tx;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 2_900_000;
    localparam int DEPTH  = 16;
    localparam int CPB    = CLK_HZ / BAUD;
`ifdef SAMPLE_UART_TX_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif
    localparam int FRAME  = NBITS * CPB;

    logic                       clk, rst_n, in_valid;
    logic [7:0]                 in_data;
    logic                       tx, busy, fifo_full, overflow;
    logic [$clog2(DEPTH):0]     fifo_count;

    sample_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .tx(tx), .busy(busy), .fifo_full(fifo_full), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each accepted sample, the edge that accepted it and the edge its frame starts on the line.
    int         acc_q[$];
    int         start_q[$];
    logic [7:0] data_q[$];
    int         edge_n = 0;
    bit         drop_now = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         ovf_seen = 0;

    function automatic int model_count(input int e);
        int c = 0;
        foreach (acc_q[i]) begin
            if (acc_q[i] <= e) c++;
            if (start_q[i] - 1 <= e) c--;
        end
        return c;
    endfunction

    function automatic bit pop_at(input int e);
        foreach (start_q[i]) if (start_q[i] - 1 == e) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_tx(input int t);
        int k;
        foreach (start_q[i]) begin
            if (t >= start_q[i] && t < start_q[i] + FRAME) begin
                k = (t - start_q[i]) / CPB;
                if (k == 0) return 1'b0;
                if (k <= 8) return data_q[i][k-1];
`ifdef SAMPLE_UART_TX_PARITY_EN
                if (k == 9) return ^data_q[i];
`endif
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int t);
        foreach (start_q[i]) if (t >= start_q[i] && t < start_q[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input bit v, input logic [7:0] d);
        int s;
        edge_n++;
        drop_now = 1'b0;
        if (v) begin
            if (model_count(edge_n - 1) < DEPTH || pop_at(edge_n)) begin
                s = edge_n + 2;
                if (start_q.size() > 0 && start_q[$] + FRAME > s) s = start_q[$] + FRAME;
                acc_q.push_back(edge_n);
                start_q.push_back(s);
                data_q.push_back(d);
            end else begin
                drop_now = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // One clock: drive inputs, let the edge happen, then compare every output on the falling edge.
    task automatic step(input bit v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        in_valid = 1'b0;
        check("tx", 32'(tx), 32'(exp_tx(edge_n)));
        check("busy", 32'(busy), 32'(exp_busy(edge_n)));
        check("fifo_count", 32'(fifo_count), 32'(model_count(edge_n)));
        check("fifo_full", 32'(fifo_full), 32'(model_count(edge_n) == DEPTH));
        check("overflow", 32'(overflow), 32'(drop_now));
        if (overflow === 1'b1) ovf_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic drain();
        int last_end;
        last_end = (start_q.size() > 0) ? start_q[$] + FRAME + 2 : edge_n;
        for (int g = 0; g < 50_000 && edge_n < last_end; g++) step(1'b0, 8'h00);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx"}, 32'(tx), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int target;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // 1: idle line stays quiet
        idle(20);

        // 2: single sample, latency and bit order
        step(1'b1, 8'hA5);
        drain();

        // 3: three consecutive strobes, frames back-to-back, no drops
        ovf_seen = 0;
        step(1'b1, 8'h01);
        step(1'b1, 8'h80);
        step(1'b1, 8'hFF);
        drain();
        check("three_no_overflow", 32'(ovf_seen), 32'd0);

        // 4: 20-strobe burst, 16 buffered + 1 in flight, 3 dropped
        ovf_seen = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom));
        idle(2);
        check("burst_overflows", 32'(ovf_seen), 32'd3);
        drain();

        // 5: asynchronous reset during data bit 3 with a second sample queued
        step(1'b1, 8'h3C);
        step(1'b1, 8'h5A);
        target = start_q[0] + 4 * CPB + CPB / 2;
        while (edge_n < target) step(1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        acc_q.delete();
        start_q.delete();
        data_q.delete();
        repeat (2) @(negedge clk);
        check_reset_values("held_reset");
        rst_n = 1'b1;
        idle(3);
        step(1'b1, 8'hC3);
        drain();

        // randomised traffic: sparse strobes, then an overflowing burst
        for (int i = 0; i < 200; i++) step($urandom_range(0, 5) == 0, 8'($urandom));
        for (int i = 0; i < 24; i++) step(1'b1, 8'($urandom));
        drain();

`ifdef SAMPLE_UART_TX_PARITY_EN
        // 6: parity values
        step(1'b1, 8'h07);
        step(1'b1, 8'h03);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
